pc_sequencer: RTL and testbench

- Parametrised program-counter sequencer; next generation of the single-register PC loader.
- Adds:
  - auto-increment by a configurable step
  - stall
  - jump load
  - call/return through an internal return-address stack (RAS) with full/empty status and a sticky error flag
- Sits at the front of the fetch stage and drives the instruction-memory address.

---
 rtl/pc_sequencer.sv | 158 +++++++++++++++
 tb/tb_pc_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch-stage program counter. Supports step increment, stall, jump,
//            and call/return through a circular return-address stack.
//            Optional macro PC_ALIGN_CHECK_EN aligns targets and pulses
//            o_Misalign when a target is misaligned.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int                    DATA_WIDTH   = 27,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    STEP         = 1,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Stall,
  input  logic                  i_Load,
  input  logic                  i_Call,
  input  logic                  i_Return,
  input  logic [DATA_WIDTH-1:0] i_PC,
  output logic [DATA_WIDTH-1:0] o_PC,
  output logic                  o_Valid,
  output logic                  o_RAS_Empty,
  output logic                  o_RAS_Full,
  output logic                  o_Error,
  output logic                  o_Misalign
);

  localparam int                    c_PTR_W = $clog2(RAS_DEPTH);
  localparam logic [DATA_WIDTH-1:0] c_STEP  = DATA_WIDTH'(STEP);
  localparam logic [c_PTR_W:0]      c_DEPTH = (c_PTR_W + 1)'(RAS_DEPTH);

  typedef enum logic [0:0] {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_valid;
  logic                  r_error;
  logic [c_PTR_W-1:0]    r_top;
  logic [c_PTR_W:0]      r_count;
  logic [DATA_WIDTH-1:0] r_ras [RAS_DEPTH];

  logic                  w_active;
  logic                  w_ras_empty;
  logic                  w_pop;
  logic                  w_underflow;
  logic                  w_push;
  logic                  w_load;
  logic                  w_take_target;
  logic [c_PTR_W-1:0]    w_push_ptr;
  logic [DATA_WIDTH-1:0] w_seq_pc;
  logic [DATA_WIDTH-1:0] w_raw_target;
  logic [DATA_WIDTH-1:0] w_target;
  logic [DATA_WIDTH-1:0] w_next_pc;

  // Request decode in priority order: stall > return > call > load > step.
  assign w_active      = (r_state == RUN) && !i_Stall;
  assign w_ras_empty   = (r_count == '0);
  assign w_pop         = w_active && i_Return && !w_ras_empty;
  assign w_underflow   = w_active && i_Return && w_ras_empty;
  assign w_push        = w_active && !i_Return && i_Call;
  assign w_load        = w_active && !i_Return && !i_Call && i_Load;
  assign w_take_target = w_pop || w_push || w_load;
  assign w_push_ptr    = r_top + c_PTR_W'(1);
  assign w_seq_pc      = r_pc + c_STEP;
  assign w_raw_target  = w_pop ? r_ras[r_top] : i_PC;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] c_ALIGN_MASK = DATA_WIDTH'(STEP - 1);

  logic w_misalign;
  logic r_misalign;

  assign w_misalign = w_take_target && ((w_raw_target & c_ALIGN_MASK) != '0);
  assign w_target   = w_raw_target & ~c_ALIGN_MASK;
  assign o_Misalign = r_misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalign;
    end
  end
`else
  assign w_target   = w_raw_target;
  assign o_Misalign = 1'b0;
`endif

  always_comb begin
    w_next_pc = r_pc;
    if (w_take_target) begin
      w_next_pc = w_target;
    end else if (w_active) begin
      w_next_pc = w_seq_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= HOLD;
      r_pc    <= RESET_VECTOR;
      r_valid <= 1'b0;
      r_error <= 1'b0;
      r_top   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        HOLD: begin
          r_state <= RUN;
          r_valid <= 1'b1;
        end
        RUN: begin
          r_pc <= w_next_pc;
          if (w_push) begin
            r_top <= w_push_ptr;
            // A full stack overwrites its oldest slot, which is the next one.
            if (r_count == c_DEPTH) begin
              r_error <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
          if (w_pop) begin
            r_top   <= r_top - c_PTR_W'(1);
            r_count <= r_count - 1'b1;
          end
          if (w_underflow || (w_active && i_Return && i_Call)) begin
            r_error <= 1'b1;
          end
        end
        default: r_state <= HOLD;
      endcase
    end
  end

  // Stack storage needs no reset; a zero count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[w_push_ptr] <= w_seq_pc;
    end
  end

  assign o_PC        = r_pc;
  assign o_Valid     = r_valid;
  assign o_Error     = r_error;
  assign o_RAS_Empty = w_ras_empty;
  assign o_RAS_Full  = (r_count == c_DEPTH);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed bench for pc_sequencer with a queue-based reference model.
//            Honours PC_ALIGN_CHECK_EN when the macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  localparam int          DW    = 27;
  localparam logic [26:0] RV    = 27'h100;
  localparam int          STEP  = 4;
  localparam int          DEPTH = 4;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          i_Stall  = 1'b0;
  logic          i_Load   = 1'b0;
  logic          i_Call   = 1'b0;
  logic          i_Return = 1'b0;
  logic [DW-1:0] i_PC     = '0;
  logic [DW-1:0] o_PC;
  logic          o_Valid;
  logic          o_RAS_Empty;
  logic          o_RAS_Full;
  logic          o_Error;
  logic          o_Misalign;

  pc_sequencer #(
    .DATA_WIDTH  (DW),
    .RESET_VECTOR(RV),
    .STEP        (STEP),
    .RAS_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_Stall    (i_Stall),
    .i_Load     (i_Load),
    .i_Call     (i_Call),
    .i_Return   (i_Return),
    .i_PC       (i_PC),
    .o_PC       (o_PC),
    .o_Valid    (o_Valid),
    .o_RAS_Empty(o_RAS_Empty),
    .o_RAS_Full (o_RAS_Full),
    .o_Error    (o_Error),
    .o_Misalign (o_Misalign)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: PC as plain modular arithmetic, stack as a bounded queue.
  logic [DW-1:0] m_pc;
  logic          m_valid, m_err, m_mis, m_run;
  logic [DW-1:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc    = RV;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_mis   = 1'b0;
    m_run   = 1'b0;
    m_ras.delete();
  endtask

  function automatic logic [DW-1:0] align(input logic [DW-1:0] t);
`ifdef PC_ALIGN_CHECK_EN
    if (int'(t) % STEP != 0) begin
      m_mis = 1'b1;
      return t - DW'(int'(t) % STEP);
    end
`endif
    return t;
  endfunction

  task automatic m_step(input logic s, input logic l, input logic c, input logic r,
                        input logic [DW-1:0] tgt);
    if (!m_run) begin
      m_run   = 1'b1;
      m_valid = 1'b1;
      m_mis   = 1'b0;
      return;
    end
    m_mis = 1'b0;
    if (s) return;
    if (r) begin
      if (c) m_err = 1'b1;
      if (m_ras.size() > 0) begin
        m_pc = align(m_ras.pop_back());
      end else begin
        m_pc  = m_pc + DW'(STEP);
        m_err = 1'b1;
      end
    end else if (c) begin
      if (m_ras.size() == DEPTH) begin
        void'(m_ras.pop_front());
        m_err = 1'b1;
      end
      m_ras.push_back(m_pc + DW'(STEP));
      m_pc = align(tgt);
    end else if (l) begin
      m_pc = align(tgt);
    end else begin
      m_pc = m_pc + DW'(STEP);
    end
  endtask

  always @(negedge clk) begin
    check("pc",    32'(o_PC),    32'(m_pc));
    check("valid", 32'(o_Valid), 32'(m_valid));
    check("empty", 32'(o_RAS_Empty), 32'(m_ras.size() == 0));
    check("full",  32'(o_RAS_Full),  32'(m_ras.size() == DEPTH));
    check("error", 32'(o_Error),     32'(m_err));
    check("misalign", 32'(o_Misalign), 32'(m_mis));
  end

  task automatic cyc(input logic s, input logic l, input logic c, input logic r,
                     input logic [DW-1:0] tgt);
    i_Stall  = s;
    i_Load   = l;
    i_Call   = c;
    i_Return = r;
    i_PC     = tgt;
    @(posedge clk);
    if (reset) m_step(s, l, c, r, tgt);
    #1;
  endtask

  logic [DW-1:0] ret_exp [5];

  initial begin
    m_reset();
    ret_exp = '{27'h7004, 27'h6004, 27'h5004, 27'h4004, 27'h4008};
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", 32'(o_PC), 32'h100);
    check("rst_valid", 32'(o_Valid), 32'h0);
    check("rst_empty", 32'(o_RAS_Empty), 32'h1);
    #1 reset = 1'b1;

    cyc(0, 0, 0, 0, '0);
    check("hold_pc", 32'(o_PC), 32'h100);
    check("hold_valid", 32'(o_Valid), 32'h1);
    cyc(0, 0, 0, 0, '0);
    check("inc1", 32'(o_PC), 32'h104);
    cyc(0, 0, 0, 0, '0);
    check("inc2", 32'(o_PC), 32'h108);

    cyc(0, 1, 0, 0, 27'h2000);
    check("jump", 32'(o_PC), 32'h2000);
    repeat (3) cyc(1, 1, 1, 1, 27'h5555);
    check("stall", 32'(o_PC), 32'h2000);
    cyc(0, 0, 0, 0, '0);
    check("post_stall", 32'(o_PC), 32'h2004);

    cyc(0, 1, 1, 0, 27'h3000);
    check("call", 32'(o_PC), 32'h3000);
    cyc(0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, '0);
    check("callee", 32'(o_PC), 32'h3008);
    cyc(0, 0, 0, 1, '0);
    check("return", 32'(o_PC), 32'h2008);
    check("ret_empty", 32'(o_RAS_Empty), 32'h1);
    check("ret_noerr", 32'(o_Error), 32'h0);

    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, DW'(32'h4000 + i * 32'h1000));
      if (i == 3) begin
        check("full_after4", 32'(o_RAS_Full), 32'h1);
        check("noerr_after4", 32'(o_Error), 32'h0);
      end
    end
    check("overflow_err", 32'(o_Error), 32'h1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, '0);
      check($sformatf("pop%0d", i), 32'(o_PC), 32'(ret_exp[i]));
    end
    check("underflow_empty", 32'(o_RAS_Empty), 32'h1);

    cyc(0, 1, 0, 0, 27'h7FFFFFC);
    cyc(0, 0, 0, 0, '0);
    check("wrap", 32'(o_PC), 32'h0);
    cyc(0, 1, 0, 0, 27'h7FFFFFC);
    cyc(0, 0, 1, 0, 27'h10);
    check("wrap_call", 32'(o_PC), 32'h10);
    cyc(0, 0, 0, 1, '0);
    check("wrap_ret", 32'(o_PC), 32'h0);

    cyc(0, 0, 1, 0, 27'h3000);
    #1 reset = 1'b0;
    m_reset();
    #1;
    check("async_pc", 32'(o_PC), 32'h100);
    check("async_empty", 32'(o_RAS_Empty), 32'h1);
    check("async_valid", 32'(o_Valid), 32'h0);
    check("async_err", 32'(o_Error), 32'h0);
    @(negedge clk);
    #1 reset = 1'b1;

    cyc(0, 0, 0, 0, '0);
    cyc(0, 0, 1, 0, 27'h3000);
    cyc(0, 0, 1, 1, 27'h5000);
    check("callret_pc", 32'(o_PC), 32'h104);
    check("callret_err", 32'(o_Error), 32'h1);

    cyc(0, 1, 0, 0, 27'h2003);
`ifdef PC_ALIGN_CHECK_EN
    check("align_pc", 32'(o_PC), 32'h2000);
    check("align_pulse", 32'(o_Misalign), 32'h1);
`else
    check("align_pc", 32'(o_PC), 32'h2003);
    check("align_pulse", 32'(o_Misalign), 32'h0);
`endif
    cyc(0, 0, 0, 0, '0);
    check("align_clear", 32'(o_Misalign), 32'h0);
    repeat (2) cyc(0, 0, 0, 0, '0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
